// File: rtl/game_pkg.sv
// Shared types and helpers for the game stage sequencer.
//   stage_t       : encoded game stage (START/BATTLE/WIN/LOSE)
//   HP_W_DEFAULT  : default hit-point counter width
//   stage_onehot  : stage -> {start, battle, win, lose} one-hot lines
package game_pkg;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_BATTLE = 2'd1,
    ST_WIN    = 2'd2,
    ST_LOSE   = 2'd3
  } stage_t;

  localparam int HP_W_DEFAULT = 8;

  // Bit order matches the port order {start_l, battle_l, win_l, lose_l}.
  function automatic logic [3:0] stage_onehot(input stage_t s);
    logic [3:0] oh;
    oh = 4'b0000;
    case (s)
      ST_START:  oh = 4'b1000;
      ST_BATTLE: oh = 4'b0100;
      ST_WIN:    oh = 4'b0010;
      ST_LOSE:   oh = 4'b0001;
      default:   oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/game_stage_ctrl_rise_detect.sv
// rise_detect: optional N-flop synchroniser followed by a rising-edge detector.
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : input level (foreign domain when SYNC_STAGES > 0)
//   rise       : combinational 1-cycle pulse on a rising edge of the
//                (synchronised) level
// With SYNC_STAGES = 0 the input is used directly and only the previous-value
// flop is kept, so rise = din & ~din_q.
module rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic level;
  logic level_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign level = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign level = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/game_stage_ctrl.sv
// game_stage_ctrl: game-level sequencer upstream of the colour mapper.
//   Clk, Reset_n        : system clock, asynchronous active-low reset
//   frame_clk           : vsync-rate level from the VGA domain (synchronised here)
//   key_enter           : Enter key level (Clk domain)
//   npc_hit, player_hit : 1-cycle hit pulses
//   start_l/battle_l/win_l/lose_l : registered one-hot stage lines
//   player_hp, npc_hp   : current hit points
//   battle_rst          : 1-cycle pulse on the first BATTLE cycle
//   frame_tick          : 1-cycle pulse per synchronised frame_clk rising edge
//   stage_dbg           : current encoded stage (debug visibility)
// Handshake note: there is no valid/ready flow here; all inputs are sampled
// every cycle and pulses are exactly one Clk cycle wide.
module game_stage_ctrl
  import game_pkg::*;
#(
  parameter int HP_W          = HP_W_DEFAULT,
  parameter int PLAYER_HP_MAX = 100,
  parameter int NPC_HP_MAX    = 100,
  parameter int DMG_TO_NPC    = 10,
  parameter int DMG_TO_PLAYER = 10,
  parameter int RESULT_FRAMES = 120
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_clk,
  input  logic            key_enter,
  input  logic            npc_hit,
  input  logic            player_hit,
  output logic            start_l,
  output logic            battle_l,
  output logic            win_l,
  output logic            lose_l,
  output logic [HP_W-1:0] player_hp,
  output logic [HP_W-1:0] npc_hp,
  output logic            battle_rst,
  output logic            frame_tick,
  output logic [1:0]      stage_dbg
);

  localparam int HOLD_W = $clog2(RESULT_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RESULT_FRAMES);
  localparam logic [HP_W-1:0]   P_HP_MAX  = HP_W'(PLAYER_HP_MAX);
  localparam logic [HP_W-1:0]   N_HP_MAX  = HP_W'(NPC_HP_MAX);
  localparam logic [HP_W-1:0]   DMG_N     = HP_W'(DMG_TO_NPC);
  localparam logic [HP_W-1:0]   DMG_P     = HP_W'(DMG_TO_PLAYER);

  stage_t            stage;
  stage_t            stage_nxt;
  logic [HP_W-1:0]   npc_hp_nxt;
  logic [HP_W-1:0]   player_hp_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              tick_raw;
  logic              enter_rise;
  logic              battle_entry;

  rise_detect #(.SYNC_STAGES(2)) u_frame_rise (
    .clk   (Clk),
    .rst_n (Reset_n),
    .din   (frame_clk),
    .rise  (tick_raw)
  );

  rise_detect #(.SYNC_STAGES(0)) u_enter_rise (
    .clk   (Clk),
    .rst_n (Reset_n),
    .din   (key_enter),
    .rise  (enter_rise)
  );

  assign battle_entry = (stage == ST_START) && enter_rise;

  // Saturating damage; hits only count while the battle is live.
  always_comb begin
    npc_hp_nxt    = npc_hp;
    player_hp_nxt = player_hp;
    if (stage == ST_BATTLE) begin
      if (npc_hit) begin
        npc_hp_nxt = (npc_hp < DMG_N) ? '0 : npc_hp - DMG_N;
      end
      if (player_hit) begin
        player_hp_nxt = (player_hp < DMG_P) ? '0 : player_hp - DMG_P;
      end
    end
  end

  // Player death is checked first so a double KO resolves to LOSE.
  always_comb begin
    stage_nxt = stage;
    case (stage)
      ST_START:  if (enter_rise) stage_nxt = ST_BATTLE;
      ST_BATTLE: begin
        if (player_hp_nxt == '0)   stage_nxt = ST_LOSE;
        else if (npc_hp_nxt == '0) stage_nxt = ST_WIN;
      end
      ST_WIN, ST_LOSE: begin
        if (enter_rise && (hold_cnt == HOLD_MAX)) stage_nxt = ST_START;
      end
      default: stage_nxt = ST_START;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stage                              <= ST_START;
      {start_l, battle_l, win_l, lose_l} <= 4'b1000;
      player_hp                          <= P_HP_MAX;
      npc_hp                             <= N_HP_MAX;
      hold_cnt                           <= '0;
      battle_rst                         <= 1'b0;
      frame_tick                         <= 1'b0;
    end else begin
      stage                              <= stage_nxt;
      {start_l, battle_l, win_l, lose_l} <= stage_onehot(stage_nxt);
      frame_tick                         <= tick_raw;
      battle_rst                         <= battle_entry;

      if (battle_entry) begin
        player_hp <= P_HP_MAX;
        npc_hp    <= N_HP_MAX;
      end else begin
        player_hp <= player_hp_nxt;
        npc_hp    <= npc_hp_nxt;
      end

      // Held at zero outside the result screens, so entry always starts from 0.
      if ((stage != ST_WIN) && (stage != ST_LOSE)) begin
        hold_cnt <= '0;
      end else if (frame_tick && (hold_cnt < HOLD_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign stage_dbg = stage;

endmodule

// File: tb/tb_game_stage_ctrl.sv
module tb_game_stage_ctrl;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic frame_clk = 1'b0;
  logic key_enter = 1'b0;
  logic npc_hit = 1'b0;
  logic player_hit = 1'b0;

  // Instance A: default parameters.
  logic       start_l, battle_l, win_l, lose_l, battle_rst, frame_tick;
  logic [7:0] player_hp, npc_hp;
  logic [1:0] stage_dbg;

  // Instance B: player HP 95 so a 5 HP residue can be reached.
  logic       b_start_l, b_battle_l, b_win_l, b_lose_l, b_battle_rst, b_frame_tick;
  logic [7:0] b_player_hp, b_npc_hp;
  logic [1:0] b_stage_dbg;

  game_stage_ctrl u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .key_enter(key_enter),
    .npc_hit(npc_hit), .player_hit(player_hit),
    .start_l(start_l), .battle_l(battle_l), .win_l(win_l), .lose_l(lose_l),
    .player_hp(player_hp), .npc_hp(npc_hp), .battle_rst(battle_rst),
    .frame_tick(frame_tick), .stage_dbg(stage_dbg)
  );

  game_stage_ctrl #(.PLAYER_HP_MAX(95)) u_dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .key_enter(key_enter),
    .npc_hit(npc_hit), .player_hit(player_hit),
    .start_l(b_start_l), .battle_l(b_battle_l), .win_l(b_win_l), .lose_l(b_lose_l),
    .player_hp(b_player_hp), .npc_hp(b_npc_hp), .battle_rst(b_battle_rst),
    .frame_tick(b_frame_tick), .stage_dbg(b_stage_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int tick_seen = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Every action happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    key_enter = 1'b0; npc_hit = 1'b0; player_hit = 1'b0; frame_clk = 1'b0;
    repeat (2) step();
    Reset_n = 1'b1;
    step();
  endtask

  task automatic enter_battle();
    key_enter = 1'b1;
    step();
    key_enter = 1'b0;
    step();
  endtask

  task automatic hit(input logic n, input logic p);
    npc_hit = n;
    player_hit = p;
    step();
    npc_hit = 1'b0;
    player_hit = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    repeat (4) begin
      step();
      if (frame_tick) tick_seen++;
    end
    frame_clk = 1'b0;
    repeat (4) begin
      step();
      if (frame_tick) tick_seen++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rst_pulses;
    logic [7:0] exp_hp;

    // Reset values
    do_reset();
    check_eq("rst_onehot", {start_l, battle_l, win_l, lose_l}, 4'b1000);
    check_eq("rst_player_hp", player_hp, 100);
    check_eq("rst_npc_hp", npc_hp, 100);
    check_eq("rst_battle_rst", battle_rst, 0);
    check_eq("rst_frame_tick", frame_tick, 0);

    // Enter held 5 cycles -> exactly one entry
    rst_pulses = 0;
    key_enter = 1'b1;
    step();
    if (battle_rst) rst_pulses++;
    check_eq("entry_battle_l", battle_l, 1);
    check_eq("entry_battle_rst", battle_rst, 1);
    check_eq("entry_hp", {player_hp, npc_hp}, {8'd100, 8'd100});
    repeat (4) begin
      step();
      if (battle_rst) rst_pulses++;
    end
    check_eq("entry_rst_pulses", rst_pulses, 1);
    check_eq("entry_still_battle", {start_l, battle_l, win_l, lose_l}, 4'b0100);
    key_enter = 1'b0;
    step();

    // 10 NPC hits -> WIN on the zero cycle
    exp_hp = 8'd100;
    for (int i = 0; i < 10; i++) begin
      exp_hp = exp_hp - 8'd10;
      exp_q.push_back(exp_hp);
    end
    for (int i = 0; i < 10; i++) begin
      hit(1'b1, 1'b0);
      check_eq($sformatf("npc_hp_%0d", i + 1), npc_hp, exp_q.pop_front());
      if (i == 8) check_eq("battle_before_kill", battle_l, 1);
    end
    check_eq("win_onehot", {start_l, battle_l, win_l, lose_l}, 4'b0010);
    hit(1'b1, 1'b1);
    check_eq("win_11th_npc_hp", npc_hp, 0);
    check_eq("win_hit_ignored_player_hp", player_hp, 100);
    check_eq("win_held", win_l, 1);

    // Result hold: Enter before 120 ticks ignored
    tick_seen = 0;
    repeat (50) frame_pulse();
    check_eq("ticks_50", tick_seen, 50);
    key_enter = 1'b1; step();
    check_eq("enter_at_50_ignored", win_l, 1);
    key_enter = 1'b0; step();
    repeat (69) frame_pulse();
    key_enter = 1'b1; step();
    check_eq("enter_at_119_ignored", win_l, 1);
    key_enter = 1'b0; step();
    frame_pulse();
    check_eq("ticks_120", tick_seen, 120);
    key_enter = 1'b1; step();
    check_eq("enter_at_120_start", {start_l, battle_l, win_l, lose_l}, 4'b1000);
    check_eq("frozen_npc_hp", npc_hp, 0);
    key_enter = 1'b0; step();

    // Player HP 5 -> 0 via saturating subtract (instance B)
    do_reset();
    enter_battle();
    check_eq("b_entry_player_hp", b_player_hp, 95);
    repeat (9) hit(1'b0, 1'b1);
    check_eq("b_player_hp_5", b_player_hp, 5);
    check_eq("a_player_hp_10", player_hp, 10);
    check_eq("b_still_battle", b_battle_l, 1);
    hit(1'b0, 1'b1);
    check_eq("b_player_hp_sat", b_player_hp, 0);
    check_eq("b_lose_onehot", {b_start_l, b_battle_l, b_win_l, b_lose_l}, 4'b0001);
    check_eq("a_lose_onehot", {start_l, battle_l, win_l, lose_l}, 4'b0001);
    check_eq("a_npc_untouched", npc_hp, 100);

    // Double KO -> LOSE
    do_reset();
    enter_battle();
    repeat (9) hit(1'b1, 1'b1);
    check_eq("dko_pre_hp", {player_hp, npc_hp}, {8'd10, 8'd10});
    hit(1'b1, 1'b1);
    check_eq("dko_hp", {player_hp, npc_hp}, 16'd0);
    check_eq("dko_lose", lose_l, 1);
    check_eq("dko_win", win_l, 0);

    // Enter ignored in battle, then async reset mid-battle
    do_reset();
    enter_battle();
    key_enter = 1'b1; step();
    check_eq("enter_in_battle", {start_l, battle_l, win_l, lose_l}, 4'b0100);
    check_eq("enter_in_battle_rst", battle_rst, 0);
    key_enter = 1'b0; step();
    repeat (6) hit(1'b1, 1'b0);
    check_eq("mid_npc_hp", npc_hp, 40);
    Reset_n = 1'b0;
    #1;
    check_eq("async_onehot", {start_l, battle_l, win_l, lose_l}, 4'b1000);
    check_eq("async_npc_hp", npc_hp, 100);
    check_eq("async_player_hp", player_hp, 100);
    check_eq("async_battle_rst", battle_rst, 0);
    step();
    Reset_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
